// File: rtl/register_file_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultDepth = 32;
    localparam int unsigned ZeroAddr     = 0;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Write, read and busy-marking signals of the register file.
interface register_file_sb_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              write_enable;
    logic [ADDR_W-1:0] write_addr;
    logic [WIDTH-1:0]  write_data;
    logic [ADDR_W-1:0] read_addr_a;
    logic [ADDR_W-1:0] read_addr_b;
    logic [WIDTH-1:0]  read_data_a;
    logic [WIDTH-1:0]  read_data_b;
    logic              set_busy;
    logic [ADDR_W-1:0] set_busy_addr;
    logic              busy_a;
    logic              busy_b;

    modport master (
        output write_enable, write_addr, write_data, read_addr_a, read_addr_b,
        output set_busy, set_busy_addr,
        input  read_data_a, read_data_b, busy_a, busy_b
    );

    modport slave (
        input  write_enable, write_addr, write_data, read_addr_a, read_addr_b,
        input  set_busy, set_busy_addr,
        output read_data_a, read_data_b, busy_a, busy_b
    );
endinterface

// File: rtl/register_file_sb_entry.sv
// One storage word plus its pending-write bit; set takes priority over clear.
module regfile_entry #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             set,
    input  logic             clr,
    output logic [WIDTH-1:0] data,
    output logic             busy
);
    logic [WIDTH-1:0] data_d, data_q;
    logic             busy_d, busy_q;

    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        if (we) data_d = wdata;
        if (set) begin
            busy_d = 1'b1;
        end else if (clr) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign data = data_q;
    assign busy = busy_q;
endmodule

// File: rtl/register_file_sb.sv
// Multi-entry register file: one write port, two combinational read ports with
// write-first bypass, and a per-entry busy scoreboard for RAW hazard stalls.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DefaultWidth,
    parameter int unsigned DEPTH    = DefaultDepth,
    parameter int unsigned ZERO_REG = 1
) (
    input logic               clock,
    input logic               reset,
    register_file_sb_if.slave bus
);
    localparam int unsigned ADDR_W = addr_width(DEPTH);

    logic [DEPTH-1:0] we_dec;
    logic [DEPTH-1:0] set_dec;
    logic [WIDTH-1:0] entry_data [DEPTH];
    logic [DEPTH-1:0] entry_busy;
    logic             byp_a, byp_b;

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == ADDR_W'(ZeroAddr)));
    endfunction

    // Zero entry is tied off by never decoding a write or set to it.
    always_comb begin
        we_dec  = '0;
        set_dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            we_dec[i]  = bus.write_enable && (bus.write_addr == ADDR_W'(i))
                         && writable(ADDR_W'(i));
            set_dec[i] = bus.set_busy && (bus.set_busy_addr == ADDR_W'(i))
                         && writable(ADDR_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        regfile_entry #(
            .WIDTH (WIDTH)
        ) u_entry (
            .clock (clock),
            .reset (reset),
            .we    (we_dec[g]),
            .wdata (bus.write_data),
            .set   (set_dec[g]),
            .clr   (we_dec[g]),
            .data  (entry_data[g]),
            .busy  (entry_busy[g])
        );
    end

    always_comb begin
        byp_a = bus.write_enable && (bus.write_addr == bus.read_addr_a)
                && writable(bus.write_addr);
        byp_b = bus.write_enable && (bus.write_addr == bus.read_addr_b)
                && writable(bus.write_addr);

        bus.read_data_a = '0;
        bus.read_data_b = '0;
        bus.busy_a      = 1'b0;
        bus.busy_b      = 1'b0;
        if (!reset) begin
            bus.read_data_a = byp_a ? bus.write_data : entry_data[bus.read_addr_a];
            bus.read_data_b = byp_b ? bus.write_data : entry_data[bus.read_addr_b];
            // A bypass hit means the producer retires this cycle.
            bus.busy_a      = entry_busy[bus.read_addr_a] && !byp_a;
            bus.busy_b      = entry_busy[bus.read_addr_b] && !byp_b;
        end
    end
endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench: stimulus queues expected read-port values, a negedge
// monitor pops and compares them against two DUTs (ZERO_REG=1 and ZERO_REG=0).
module tb_register_file_sb;
    localparam int unsigned W  = 32;
    localparam int unsigned D  = 32;
    localparam int unsigned AW = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    register_file_sb_if #(.WIDTH(W), .ADDR_W(AW)) bus_z ();
    register_file_sb_if #(.WIDTH(W), .ADDR_W(AW)) bus_n ();

    register_file_sb #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut_z (
        .clock (clock),
        .reset (reset),
        .bus   (bus_z)
    );

    register_file_sb #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0)) dut_n (
        .clock (clock),
        .reset (reset),
        .bus   (bus_n)
    );

    typedef struct {
        int          dut;
        string       name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic        ba;
        logic        bb;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t         m_e;
    logic [W-1:0] m_a, m_b;
    logic         m_ba, m_bb;

    always @(negedge clock) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            if (m_e.dut == 0) begin
                m_a = bus_z.read_data_a; m_b = bus_z.read_data_b;
                m_ba = bus_z.busy_a;     m_bb = bus_z.busy_b;
            end else begin
                m_a = bus_n.read_data_a; m_b = bus_n.read_data_b;
                m_ba = bus_n.busy_a;     m_bb = bus_n.busy_b;
            end
            n_cmp++;
            if (m_a !== m_e.a || m_b !== m_e.b || m_ba !== m_e.ba || m_bb !== m_e.bb) begin
                n_bad++;
                $display("FAIL %s dut%0d: got a=%h b=%h busy_a=%b busy_b=%b, want a=%h b=%h busy_a=%b busy_b=%b",
                         m_e.name, m_e.dut, m_a, m_b, m_ba, m_bb, m_e.a, m_e.b, m_e.ba, m_e.bb);
            end
        end
    end

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic sb, input logic [AW-1:0] sa,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        bus_z.write_enable = we; bus_z.write_addr = wa; bus_z.write_data = wd;
        bus_z.set_busy = sb; bus_z.set_busy_addr = sa;
        bus_z.read_addr_a = ra; bus_z.read_addr_b = rb;
        bus_n.write_enable = we; bus_n.write_addr = wa; bus_n.write_data = wd;
        bus_n.set_busy = sb; bus_n.set_busy_addr = sa;
        bus_n.read_addr_a = ra; bus_n.read_addr_b = rb;
    endtask

    task automatic expect_one(input int dut, input string name, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic ba, input logic bb);
        exp_t e;
        e.dut = dut; e.name = name; e.a = a; e.b = b; e.ba = ba; e.bb = bb;
        q.push_back(e);
    endtask

    task automatic expect_both(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ba, input logic bb);
        expect_one(0, name, a, b, ba, bb);
        expect_one(1, name, a, b, ba, bb);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
        cyc();

        // Reset held for two edges with a write and set_busy that must be ignored.
        reset = 1'b1;
        drive(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 5'd5, 5'd0);
        expect_both("reset_forced0", '0, '0, 1'b0, 1'b0);
        cyc();
        expect_both("reset_forced1", '0, '0, 1'b0, 1'b0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0, AW'(i), AW'(31 - i));
            expect_both("reset_clear", '0, '0, 1'b0, 1'b0);
            cyc();
        end

        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd5);
        expect_both("write5_bypass", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd5);
        expect_both("read5", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
        cyc();

        drive(1'b1, 5'd7, 32'h12345678, 1'b0, '0, 5'd7, 5'd6);
        expect_both("bypass7", 32'h12345678, '0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd5);
        expect_both("read7_5", 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0);
        cyc();

        // Entry 0: hardwired on dut0, ordinary on dut1.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        expect_one(0, "zero_wr_cycle", '0, '0, 1'b0, 1'b0);
        expect_one(1, "zero_wr_cycle", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0);
        expect_one(0, "zero_after", '0, '0, 1'b0, 1'b0);
        expect_one(1, "zero_after", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        cyc();

        drive(1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
        expect_both("setbusy9_same", '0, '0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
        expect_both("busy9_next", '0, '0, 1'b1, 1'b1);
        cyc();
        drive(1'b1, 5'd9, 32'h99, 1'b0, '0, 5'd9, 5'd9);
        expect_both("write9_bypass", 32'h99, 32'h99, 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
        expect_both("busy9_cleared", 32'h99, 32'h99, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 5'd9, 32'h1234, 1'b1, 5'd9, 5'd9, 5'd9);
        expect_both("set_and_write9", 32'h1234, 32'h1234, 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
        expect_both("set_wins9", 32'h1234, 32'h1234, 1'b1, 1'b1);
        cyc();

        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, AW'(i), W'(i), (i == 4), 5'd3, 5'd9, 5'd9);
            expect_both("fill", 32'h1234, 32'h1234, 1'b1, 1'b1);
            cyc();
        end
        drive(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd4);
        expect_both("filled3_4", 32'd3, 32'd4, 1'b1, 1'b0);
        cyc();
        reset = 1'b1;
        drive(1'b1, 5'd2, 32'h77, 1'b1, 5'd2, 5'd3, 5'd4);
        expect_both("midreset_forced", '0, '0, 1'b0, 1'b0);
        cyc();
        reset = 1'b0;
        drive(1'b1, 5'd2, 32'h55, 1'b0, '0, 5'd3, 5'd9);
        expect_both("post_reset_3_9", '0, '0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, 5'd2, 5'd1);
        expect_both("post_reset_write2", 32'h55, '0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, 5'd4, 5'd0);
        expect_both("post_reset_4_0", '0, '0, 1'b0, 1'b0);
        cyc();

        @(negedge clock);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised multi-entry register file for the processor datapath: one write port, two asynchronous read ports, and a per-entry busy scoreboard for hazard detection in the pipeline. It is the successor to the single-word enable-gated register. It adds:
- depth and address decode;
- write-to-read bypass;
- an optional hardwired zero entry;
- pending-write (busy) tracking, so decode can stall on RAW hazards.

Parameters:
WIDTH, 32, data bits per entry
DEPTH, 32, number of entries (power of two, >= 2)
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes and never goes busy

Ports:
clock  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all entries and busy bits
write_enable  input  1  commit write_data to write_addr this edge
write_addr  input  ADDR_W  write target
write_data  input  WIDTH  write value
read_addr_a  input  ADDR_W  read port A address
read_addr_b  input  ADDR_W  read port B address
read_data_a  output  WIDTH  port A data (combinational)
read_data_b  output  WIDTH  port B data (combinational)
set_busy  input  1  mark set_busy_addr as having a pending producer
set_busy_addr  input  ADDR_W  entry to mark busy
busy_a  output  1  entry at read_addr_a has a pending write
busy_b  output  1  entry at read_addr_b has a pending write

Behaviour:
- Storage: DEPTH x WIDTH flops plus DEPTH busy flops. No other state.
- Reset: on a rising edge with reset=1, all entries become 0 and all busy bits become 0. Write and set_busy are ignored on that edge.
  - While reset=1, read_data_a/b are forced to 0 and busy_a/b to 0, independent of address.
  - Reset asserted mid-sequence discards any pending writes and busy marks. The first edge after deassertion behaves normally.
- Write: entry[write_addr] <= write_data on the edge with write_enable=1. The value is visible one edge later via storage.
- Read: combinational decode, zero-cycle latency. Both ports are independent and may address the same entry.
- Bypass: if write_enable=1, write_addr==read_addr_x and the entry is writable, read_data_x = write_data in the same cycle (write-first).
  - Bypass also clears busy_x in that cycle: the producer is completing.
- Zero entry (ZERO_REG=1):
  - Address 0 always reads 0 and is never bypassed.
  - Writes to 0 are dropped.
  - set_busy on 0 is dropped and busy for address 0 is always 0.
- Busy scoreboard, per entry:
  - Next busy[i] = set_busy && set_busy_addr==i ? 1 : (write_enable && write_addr==i ? 0 : busy[i]).
  - If set and clear hit the same entry on the same edge, set wins: the new producer supersedes the retiring one.
  - A write to a non-busy entry is legal and leaves it not busy.
  - busy_x = busy[read_addr_x] && !(bypass hit on port x).
- Address range: DEPTH is a power of two, so all addresses are valid. There is no wrap or out-of-range case.
- No X propagation: every output is defined from reset onward.

Decomposition:
- Shared package regfile_pkg:
  - default WIDTH and DEPTH constants;
  - ZERO_ADDR constant;
  - a function computing ADDR_W.
- One sub-module, regfile_entry: WIDTH-bit storage word plus its busy bit, with write enable, set, clear and synchronous reset inputs.
  - Instantiated DEPTH times via generate.
  - Index 0 is tied off when ZERO_REG=1.
- Top level holds the decoders, read muxes and bypass logic.

Test Plan:
- Reset check: reset=1 for 2 edges, then read addrs 0..31 -> all read_data=0, all busy=0. With reset held, any write is ignored.
- Write/read: write 0xDEADBEEF to addr 5, then read A=5, B=5 on the next cycle -> both 0xDEADBEEF.
- Bypass: same cycle, write_enable=1, addr 7, data 0x12345678, read_addr_a=7 -> read_data_a=0x12345678 combinationally, while read_data_b at addr 6 is unchanged.
- Zero entry: write 0xFFFFFFFF to addr 0 and set_busy on addr 0, then read addr 0 -> data 0 and busy_a=0. Repeat with ZERO_REG=0 -> data 0xFFFFFFFF and busy_a=1.
- Scoreboard:
  - set_busy addr 9 -> busy_a=1 next cycle at read_addr_a=9;
  - write addr 9 -> busy_a=0 in the write cycle (bypass) and stays 0 after;
  - simultaneous set_busy and write to addr 9 -> busy=1 after the edge, data updated.
- Reset mid-operation: fill addrs 1..4 with 1..4 and mark 3 busy, then pulse reset one edge -> entries 1..4 read 0 and busy_a for addr 3 reads 0.
